hazard_stall_ctrl: RTL
======================

# hazard_stall_ctrl

Parametrised stall/flush controller for the five-stage pipeline, the successor of the current four-case hazard unit. It replaces fixed per-instruction-class stall equations with a generic Tuse/Tnew comparison over the E, M and W stages. It adds a multi-cycle multiply/divide busy tracker with a latency counter. It also adds a no-forwarding mode for bring-up builds. It sits beside the D-stage register file read and drives the PC enable, the D-register enable and the E-register flush.

## Interface
Parameters:
- `RA_W`, 5, register address width; address 0 is never a hazard
- `T_W`, 2, width of Tuse/Tnew fields
- `MULT_CYCLES`, 5, multiply busy cycles after start; must be 1..255
- `DIV_CYCLES`, 10, divide busy cycles after start; must be 1..255
- `FWD_EN`, 1, 1 = full forwarding network present; 0 = no forwarding, stall on any pending write

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous reset, active-low
- `rs_d`, `rt_d`  in  RA_W  D-stage source registers
- `tuse_rs_d`, `tuse_rt_d`  in  T_W  cycles until the D instruction needs rs/rt; all-ones = not read
- `wa_e`, `wa_m`, `wa_w`  in  RA_W  destination register per stage; 0 = no write
- `tnew_e`, `tnew_m`  in  T_W  cycles until the result is produced; W is always 0
- `md_use_d`  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- `md_start_e`  in  1  E instruction is mult/multu/div/divu
- `md_div_e`  in  1  qualifies md_start_e: 1 = divide
- `stall_pc`  out  1  hold PC
- `stall_d`  out  1  hold D register
- `flush_e`  out  1  insert bubble into E register
- `md_start`  out  1  one-cycle start pulse to the MD unit
- `md_busy`  out  1  MD unit computing

## Operation
- Data stall, FWD_EN=1: for each source s in {rs, rt}:
  - s≠0, tuse_s≠all-ones, and s==wa_e with tuse_s < tnew_e → stall.
  - Same test against wa_m/tnew_m → stall.
  - W never causes a stall.
- Data stall, FWD_EN=0: s≠0, tuse_s≠all-ones, and s equals any of wa_e/wa_m/wa_w → stall. Tnew is ignored.
- MD stall: md_use_d & (md_busy | md_start_e).
- stall = data stall | MD stall. stall_pc = stall_d = flush_e = stall. All three are combinational in the same cycle.
- MD counter:
  - 8-bit `cnt`; reset value 0.
  - If md_start: load MULT_CYCLES, or DIV_CYCLES when md_div_e.
  - Else if cnt≠0: decrement.
- md_start = md_start_e & (cnt==0). md_busy = (cnt≠0).
- md_start_e with cnt≠0 cannot occur legally, because the MD stall prevents it. If it occurs anyway, the start is ignored and the counter is not reloaded.

## Timing
- Reset values: cnt=0, so md_busy=0. All other outputs are combinational and are 0 when inputs are idle.
- Start in cycle t: md_busy is high in cycles t+1 through t+N, where N = MULT_CYCLES or DIV_CYCLES.
  - An MD instruction in D is stalled in cycles t through t+N.
  - It advances at the end of cycle t+N+1's evaluation, i.e. the first cycle with md_busy=0.
- Reset asserted mid-operation: cnt clears at the next edge and md_busy drops in the following cycle. Stalls then depend only on current inputs.
- A stall during the MD start cycle: the E instruction still advances, because flush_e bubbles only what enters E. The start pulse is issued exactly once.

## Structure
- Shared package `hazard_pkg`:
  - constant `TUSE_NONE` (all-ones)
  - function `src_hazard(s, tuse, wa, tnew)`
- One sub-module, `md_busy_cnt`, holds the counter, md_start and md_busy.
- The top level is combinational glue plus one instance of md_busy_cnt.

## Test plan
- lw in E writing $8 (wa_e=8, tnew_e=2); addu in D reading rs_d=8 with tuse=1 → stall_pc=stall_d=flush_e=1. Next cycle (wa_m=8, tnew_m=1) → 0.
- beq in D (tuse_rs=0, rs_d=9); addu in E writing $9 (tnew_e=1) → stall=1. rs_d=0 with the same inputs → stall=0.
- FWD_EN=0 build: rs_d=5 and wa_w=5 → stall=1. In the FWD_EN=1 build, the same stimulus → stall=0.
- md_start_e=1, md_div_e=0 in cycle 0; mflo in D from cycle 0 → md_start pulses once in cycle 0, md_busy=1 in cycles 1–5, stall=1 in cycles 0–5, 0 in cycle 6.
- div started (DIV_CYCLES=10); rst_n=0 in cycle 4 → cnt=0 after the edge, md_busy=0 from cycle 5, no stall afterwards.
- md_start_e asserted while cnt=3 → no md_start pulse and no reload; md_busy falls 3 cycles later.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and the per-source hazard test used by the stall/flush controller.
package hazard_pkg;

  // Internal working widths; narrower module fields are zero-extended into these.
  localparam int HZ_RA_W = 8;
  localparam int HZ_T_W  = 8;

  typedef logic [HZ_RA_W-1:0] hz_ra_t;
  typedef logic [HZ_T_W-1:0]  hz_t_t;

  localparam hz_t_t TUSE_NONE = {HZ_T_W{1'b1}};

  // Source s must wait for the producer at wa if it needs the value before it exists.
  function automatic logic src_hazard(input hz_ra_t s, input hz_t_t tuse,
                                      input hz_ra_t wa, input hz_t_t tnew);
    return (s != '0) && (tuse != TUSE_NONE) && (s == wa) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide busy tracker: issues the start pulse and counts down the unit latency.
module md_busy_cnt #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_e,
  input  logic md_div_e,
  output logic md_start,
  output logic md_busy
);

  localparam logic [7:0] MULT_LD = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_LD  = 8'(DIV_CYCLES);

  logic [7:0] cnt;

  // A start arriving while busy is dropped rather than restarting the count.
  assign md_start = md_start_e && (cnt == 8'd0);
  assign md_busy  = (cnt != 8'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (md_start) begin
      cnt <= md_div_e ? DIV_LD : MULT_LD;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: Tuse/Tnew data hazards over E/M/W plus mult/div busy interlock.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W        = 5,
  parameter int T_W         = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int FWD_EN      = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] rs_d,
  input  logic [RA_W-1:0] rt_d,
  input  logic [T_W-1:0]  tuse_rs_d,
  input  logic [T_W-1:0]  tuse_rt_d,
  input  logic [RA_W-1:0] wa_e,
  input  logic [RA_W-1:0] wa_m,
  input  logic [RA_W-1:0] wa_w,
  input  logic [T_W-1:0]  tnew_e,
  input  logic [T_W-1:0]  tnew_m,
  input  logic            md_use_d,
  input  logic            md_start_e,
  input  logic            md_div_e,
  output logic            stall_pc,
  output logic            stall_d,
  output logic            flush_e,
  output logic            md_start,
  output logic            md_busy
);

  hz_ra_t rs_x, rt_x, wa_e_x, wa_m_x, wa_w_x;
  hz_t_t  tuse_rs_x, tuse_rt_x, tnew_e_x, tnew_m_x;
  logic   data_stall, md_stall, stall;

  assign rs_x   = HZ_RA_W'(rs_d);
  assign rt_x   = HZ_RA_W'(rt_d);
  assign wa_e_x = HZ_RA_W'(wa_e);
  assign wa_m_x = HZ_RA_W'(wa_m);
  assign wa_w_x = HZ_RA_W'(wa_w);

  // The narrow "not read" code must map onto the wide one, not just zero-extend.
  assign tuse_rs_x = (tuse_rs_d == {T_W{1'b1}}) ? TUSE_NONE : HZ_T_W'(tuse_rs_d);
  assign tuse_rt_x = (tuse_rt_d == {T_W{1'b1}}) ? TUSE_NONE : HZ_T_W'(tuse_rt_d);
  assign tnew_e_x  = HZ_T_W'(tnew_e);
  assign tnew_m_x  = HZ_T_W'(tnew_m);

  generate
    if (FWD_EN != 0) begin : g_fwd
      assign data_stall = src_hazard(rs_x, tuse_rs_x, wa_e_x, tnew_e_x)
                        | src_hazard(rs_x, tuse_rs_x, wa_m_x, tnew_m_x)
                        | src_hazard(rt_x, tuse_rt_x, wa_e_x, tnew_e_x)
                        | src_hazard(rt_x, tuse_rt_x, wa_m_x, tnew_m_x);
    end else begin : g_nofwd
      // A maximal Tnew makes any read of a pending write a hazard, at every stage.
      assign data_stall = src_hazard(rs_x, tuse_rs_x, wa_e_x, TUSE_NONE)
                        | src_hazard(rs_x, tuse_rs_x, wa_m_x, TUSE_NONE)
                        | src_hazard(rs_x, tuse_rs_x, wa_w_x, TUSE_NONE)
                        | src_hazard(rt_x, tuse_rt_x, wa_e_x, TUSE_NONE)
                        | src_hazard(rt_x, tuse_rt_x, wa_m_x, TUSE_NONE)
                        | src_hazard(rt_x, tuse_rt_x, wa_w_x, TUSE_NONE);
    end
  endgenerate

  md_busy_cnt #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_start_e(md_start_e),
    .md_div_e  (md_div_e),
    .md_start  (md_start),
    .md_busy   (md_busy)
  );

  assign md_stall = md_use_d && (md_busy || md_start_e);
  assign stall    = data_stall || md_stall;
  assign stall_pc = stall;
  assign stall_d  = stall;
  assign flush_e  = stall;

endmodule
